// File: rtl/tx_slot_scheduler.sv
// PPS-aligned transmission slot scheduler.
// Arbitrates Costas and PSK requests into one timed slot per accepted PPS edge:
// fq_ud pulse, then trigger plus gated symbol clock for the granted mode, then a guard gap.
module tx_slot_scheduler #(
    parameter int unsigned CLK_HZ             = 10_000_000,
    parameter int unsigned PSK_SIGNAL_RATE_HZ = 125,
    parameter int unsigned COSTAS_DIV         = 100_000,
    parameter int unsigned COSTAS_LEN         = 12,
    parameter int unsigned PSK_LEN            = 250,
    parameter int unsigned FQ_UD_CYCLES       = 4,
    parameter int unsigned GUARD_CYCLES       = 1000
) (
    input  logic clk10M_w,
    input  logic rst_n,
    input  logic pps,
    input  logic costas_txrq,
    input  logic psk_txrq,
    output logic fq_ud,
    output logic mcu_costas_trigger,
    output logic mcu_costas_clk,
    output logic mcu_psk_trigger,
    output logic mcu_psk_clk,
    output logic busy
);

    localparam int unsigned PSK_DIV = CLK_HZ / PSK_SIGNAL_RATE_HZ;
    localparam int unsigned DIV_MAX = (COSTAS_DIV > PSK_DIV) ? COSTAS_DIV : PSK_DIV;
    localparam int unsigned LEN_MAX = (COSTAS_LEN > PSK_LEN) ? COSTAS_LEN : PSK_LEN;
    localparam int unsigned PH_MAX  = (FQ_UD_CYCLES > GUARD_CYCLES) ? FQ_UD_CYCLES : GUARD_CYCLES;
    localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int unsigned LEN_W   = (LEN_MAX > 1) ? $clog2(LEN_MAX) : 1;
    localparam int unsigned PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    // Elaboration-time parameter sanity checks
    if ((PSK_DIV < 2) || ((PSK_DIV % 2) != 0) || ((PSK_DIV * PSK_SIGNAL_RATE_HZ) != CLK_HZ)) begin : g_bad_psk_div
        $error("tx_slot_scheduler: CLK_HZ/PSK_SIGNAL_RATE_HZ must be an even integer >= 2");
    end
    if ((COSTAS_DIV < 2) || ((COSTAS_DIV % 2) != 0)) begin : g_bad_costas_div
        $error("tx_slot_scheduler: COSTAS_DIV must be even and >= 2");
    end
    if ((COSTAS_LEN < 1) || (COSTAS_LEN > 255)) begin : g_bad_costas_len
        $error("tx_slot_scheduler: COSTAS_LEN must be 1..255");
    end
    if ((PSK_LEN < 1) || (PSK_LEN > 65535)) begin : g_bad_psk_len
        $error("tx_slot_scheduler: PSK_LEN must be 1..65535");
    end
    if ((FQ_UD_CYCLES < 1) || (GUARD_CYCLES < 1)) begin : g_bad_phase
        $error("tx_slot_scheduler: FQ_UD_CYCLES and GUARD_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FQ,
        ST_TX,
        ST_GUARD
    } state_t;

    typedef enum logic {
        MODE_COSTAS,
        MODE_PSK
    } mode_t;

    // Bit 2: pps, bit 1: costas_txrq, bit 0: psk_txrq
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] sync3;
    logic [2:0] rise;
    logic       pps_rise;

    logic pend_costas;
    logic pend_psk;
    logic clr_costas_c;
    logic clr_psk_c;

    state_t state, state_n;
    mode_t  grant, grant_n;
    mode_t  last_grant, last_grant_n;
    mode_t  pick_c;

    logic [PH_W-1:0]  phase, phase_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [LEN_W-1:0] sym_cnt, sym_n;

    logic [DIV_W-1:0] div_last_c;
    logic [DIV_W-1:0] div_half_n_c;
    logic [LEN_W-1:0] sym_last_c;
    logic             tx_n_c;
    logic             sym_clk_n_c;

    // Two-flop synchronizers plus registered rising-edge detect for all async inputs
    always_ff @(posedge clk10M_w or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            rise  <= '0;
        end else begin
            sync1 <= {pps, costas_txrq, psk_txrq};
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
        end
    end

    assign pps_rise = rise[2];

    // Sticky pending bits: set on request edge, cleared on grant; a new edge wins over a clear
    always_ff @(posedge clk10M_w or negedge rst_n) begin
        if (!rst_n) begin
            pend_costas <= 1'b0;
            pend_psk    <= 1'b0;
        end else begin
            pend_costas <= (pend_costas & ~clr_costas_c) | rise[1];
            pend_psk    <= (pend_psk & ~clr_psk_c) | rise[0];
        end
    end

    // Arbitration: single pending wins, otherwise alternate against the last grant
    always_comb begin
        pick_c = MODE_PSK;
        if (pend_costas && pend_psk) begin
            pick_c = (last_grant == MODE_PSK) ? MODE_COSTAS : MODE_PSK;
        end else if (pend_costas) begin
            pick_c = MODE_COSTAS;
        end
    end

    // Per-mode slot geometry
    always_comb begin
        div_last_c   = (grant == MODE_COSTAS) ? DIV_W'(COSTAS_DIV - 1) : DIV_W'(PSK_DIV - 1);
        sym_last_c   = (grant == MODE_COSTAS) ? LEN_W'(COSTAS_LEN - 1) : LEN_W'(PSK_LEN - 1);
        div_half_n_c = (grant_n == MODE_COSTAS) ? DIV_W'(COSTAS_DIV / 2) : DIV_W'(PSK_DIV / 2);
    end

    // State, grant and counter registers
    always_ff @(posedge clk10M_w or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= MODE_PSK;
            last_grant <= MODE_PSK;
            phase      <= '0;
            div_cnt    <= '0;
            sym_cnt    <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            phase      <= phase_n;
            div_cnt    <= div_n;
            sym_cnt    <= sym_n;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        phase_n      = phase;
        div_n        = div_cnt;
        sym_n        = sym_cnt;
        clr_costas_c = 1'b0;
        clr_psk_c    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pps_rise && (pend_costas || pend_psk)) begin
                    state_n      = ST_FQ;
                    grant_n      = pick_c;
                    last_grant_n = pick_c;
                    phase_n      = '0;
                    clr_costas_c = (pick_c == MODE_COSTAS);
                    clr_psk_c    = (pick_c == MODE_PSK);
                end
            end
            ST_FQ: begin
                if (phase == PH_W'(FQ_UD_CYCLES - 1)) begin
                    state_n = ST_TX;
                    div_n   = '0;
                    sym_n   = '0;
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            ST_TX: begin
                if (div_cnt == div_last_c) begin
                    div_n = '0;
                    if (sym_cnt == sym_last_c) begin
                        state_n = ST_GUARD;
                        phase_n = '0;
                    end else begin
                        sym_n = sym_cnt + LEN_W'(1);
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            ST_GUARD: begin
                if (phase == PH_W'(GUARD_CYCLES - 1)) begin
                    state_n = ST_IDLE;
                end else begin
                    phase_n = phase + PH_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Output decode on next-state values so every output is a flop aligned with the state
    always_comb begin
        tx_n_c      = (state_n == ST_TX);
        sym_clk_n_c = tx_n_c && (div_n < div_half_n_c);
    end

    // Registered outputs
    always_ff @(posedge clk10M_w or negedge rst_n) begin
        if (!rst_n) begin
            fq_ud              <= 1'b0;
            mcu_costas_trigger <= 1'b0;
            mcu_costas_clk     <= 1'b0;
            mcu_psk_trigger    <= 1'b0;
            mcu_psk_clk        <= 1'b0;
            busy               <= 1'b0;
        end else begin
            fq_ud              <= (state_n == ST_FQ);
            mcu_costas_trigger <= tx_n_c && (grant_n == MODE_COSTAS);
            mcu_costas_clk     <= sym_clk_n_c && (grant_n == MODE_COSTAS);
            mcu_psk_trigger    <= tx_n_c && (grant_n == MODE_PSK);
            mcu_psk_clk        <= sym_clk_n_c && (grant_n == MODE_PSK);
            busy               <= (state_n != ST_IDLE);
        end
    end

endmodule
